// File: rtl/damage_if.sv
// Handshake and health-counter control bundle between the damage scheduler
// and its surroundings (attack detection, frame timing, health counter).
interface damage_if;
    logic        start;
    logic        tick;
    logic        hit1_req;
    logic [7:0]  hit1_dmg;
    logic        hit2_req;
    logic [7:0]  hit2_dmg;
    logic        over;
    logic        hit1_ack;
    logic        hit2_ack;
    logic [15:0] blood_dec;
    logic        fresh;
    logic        keep;
    logic        p1_invuln;
    logic        p2_invuln;
    logic [2:0]  round_state;

    modport master (
        output start, tick, hit1_req, hit1_dmg, hit2_req, hit2_dmg, over,
        input  hit1_ack, hit2_ack, blood_dec, fresh, keep, p1_invuln, p2_invuln, round_state
    );

    modport slave (
        input  start, tick, hit1_req, hit1_dmg, hit2_req, hit2_dmg, over,
        output hit1_ack, hit2_ack, blood_dec, fresh, keep, p1_invuln, p2_invuln, round_state
    );
endinterface

// File: rtl/damage_scheduler.sv
// Round controller and hit arbiter for the packed two-player health counter:
// sequences the round and turns hit requests into safe blood_dec/fresh strobes.
module damage_scheduler #(
    parameter int unsigned COUNTDOWN_TICKS = 180,
    parameter int unsigned INVULN_TICKS    = 30,
    parameter logic [7:0]  DMG_MAX         = 8'd40
) (
    input  logic     clk,
    input  logic     reset,
    damage_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_WAIT   = 3'd2,
        S_LOAD   = 3'd3,
        S_PULSE  = 3'd4,
        S_SETTLE = 3'd5,
        S_KO     = 3'd6
    } state_t;

    localparam logic [15:0] CD_LOAD  = 16'(COUNTDOWN_TICKS);
    localparam logic [15:0] INV_LOAD = 16'(INVULN_TICKS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        settle_q, settle_d;
    logic [15:0] blood_q, blood_d;
    logic        fresh_q, fresh_d;
    logic        keep_q, keep_d;
    logic        ack1_q, ack1_d;
    logic        ack2_q, ack2_d;
    logic [15:0] inv1_q, inv1_d;
    logic [15:0] inv2_q, inv2_d;
    logic        p1_inv_q, p1_inv_d;
    logic        p2_inv_q, p2_inv_d;
    logic [7:0]  hit1_val;
    logic [7:0]  hit2_val;
    logic        timers_run;

    function automatic logic [7:0] clamp_dmg(input logic [7:0] dmg);
        if (dmg > DMG_MAX) begin
            return DMG_MAX;
        end else begin
            return dmg;
        end
    endfunction

    // Applied damage per side: clamped, zeroed when idle or target is immune
    always_comb begin
        hit1_val = 8'd0;
        hit2_val = 8'd0;
        if (bus.hit1_req && !p2_inv_q) begin
            hit1_val = clamp_dmg(bus.hit1_dmg);
        end else begin
            hit1_val = 8'd0;
        end
        if (bus.hit2_req && !p1_inv_q) begin
            hit2_val = clamp_dmg(bus.hit2_dmg);
        end else begin
            hit2_val = 8'd0;
        end
    end

    // Round FSM next state, counter strobes and invulnerability timers
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = 1'b0;
        blood_d    = blood_q;
        fresh_d    = 1'b0;
        ack1_d     = 1'b0;
        ack2_d     = 1'b0;
        inv1_d     = inv1_q;
        inv2_d     = inv2_q;
        timers_run = bus.tick && (state_q inside {S_WAIT, S_LOAD, S_PULSE, S_SETTLE});

        if (timers_run && (inv1_q != 16'd0)) begin
            inv1_d = inv1_q - 16'd1;
        end else begin
            inv1_d = inv1_q;
        end
        if (timers_run && (inv2_q != 16'd0)) begin
            inv2_d = inv2_q - 16'd1;
        end else begin
            inv2_d = inv2_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COUNT;
                    cnt_d   = CD_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COUNT: begin
                // A zero-length countdown leaves on the first COUNT cycle
                if (cnt_q == 16'd0) begin
                    state_d = S_WAIT;
                end else if (bus.tick) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_COUNT;
                    end
                end else begin
                    state_d = S_COUNT;
                end
            end
            S_WAIT: begin
                if (bus.hit1_req || bus.hit2_req) begin
                    state_d = S_LOAD;
                    ack1_d  = bus.hit1_req;
                    ack2_d  = bus.hit2_req;
                    blood_d = {hit2_val, hit1_val};
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_LOAD: begin
                // Reload wins over a same-cycle tick decrement
                if (blood_q[7:0] != 8'd0) begin
                    inv2_d = INV_LOAD;
                end else begin
                    inv2_d = inv2_d;
                end
                if (blood_q[15:8] != 8'd0) begin
                    inv1_d = INV_LOAD;
                end else begin
                    inv1_d = inv1_d;
                end
                if (blood_q == 16'd0) begin
                    state_d = S_WAIT;
                    blood_d = 16'd0;
                end else begin
                    state_d = S_PULSE;
                    fresh_d = 1'b1;
                end
            end
            S_PULSE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Second SETTLE cycle covers the counter's register latency before over is trusted
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else begin
                    blood_d = 16'd0;
                    if (bus.over) begin
                        state_d = S_KO;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_KO: begin
                state_d = S_KO;
            end
            default: begin
                state_d = S_IDLE;
                blood_d = 16'd0;
            end
        endcase

        keep_d   = (state_d inside {S_IDLE, S_COUNT, S_KO});
        p1_inv_d = (inv1_d != 16'd0);
        p2_inv_d = (inv2_d != 16'd0);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            settle_q <= 1'b0;
            blood_q  <= 16'd0;
            fresh_q  <= 1'b0;
            keep_q   <= 1'b1;
            ack1_q   <= 1'b0;
            ack2_q   <= 1'b0;
            inv1_q   <= 16'd0;
            inv2_q   <= 16'd0;
            p1_inv_q <= 1'b0;
            p2_inv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            blood_q  <= blood_d;
            fresh_q  <= fresh_d;
            keep_q   <= keep_d;
            ack1_q   <= ack1_d;
            ack2_q   <= ack2_d;
            inv1_q   <= inv1_d;
            inv2_q   <= inv2_d;
            p1_inv_q <= p1_inv_d;
            p2_inv_q <= p2_inv_d;
        end
    end

    assign bus.round_state = state_q;
    assign bus.blood_dec   = blood_q;
    assign bus.fresh       = fresh_q;
    assign bus.keep        = keep_q;
    assign bus.hit1_ack    = ack1_q;
    assign bus.hit2_ack    = ack2_q;
    assign bus.p1_invuln   = p1_inv_q;
    assign bus.p2_invuln   = p2_inv_q;
endmodule

// File: tb/tb_damage_scheduler.sv
// Directed bench for damage_scheduler: countdown, single/merged hits, immunity,
// KO lock-out and asynchronous reset during a fresh pulse.
module tb_damage_scheduler;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    damage_if bus ();

    damage_scheduler #(
        .COUNTDOWN_TICKS(3),
        .INVULN_TICKS(4),
        .DMG_MAX(8'd40)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.tick     = 1'b0;
        bus.hit1_req = 1'b0;
        bus.hit1_dmg = 8'd0;
        bus.hit2_req = 1'b0;
        bus.hit2_dmg = 8'd0;
        bus.over     = 1'b0;
        step();
        step();
        chk("rst_state", {13'd0, bus.round_state}, 16'd0);
        chk("rst_keep", {15'd0, bus.keep}, 16'd1);
        chk("rst_fresh", {15'd0, bus.fresh}, 16'd0);
        chk("rst_blood", bus.blood_dec, 16'd0);
        chk("rst_acks", {14'd0, bus.hit1_ack, bus.hit2_ack}, 16'd0);
        chk("rst_invuln", {14'd0, bus.p1_invuln, bus.p2_invuln}, 16'd0);
        reset = 1'b0;
        step();
        chk("idle_hold", {13'd0, bus.round_state}, 16'd0);

        // Countdown of 3 ticks
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("count_enter", {13'd0, bus.round_state}, 16'd1);
        chk("count_keep", {15'd0, bus.keep}, 16'd1);
        do_tick();
        chk("count_t1", {13'd0, bus.round_state}, 16'd1);
        do_tick();
        chk("count_t2", {13'd0, bus.round_state}, 16'd1);
        chk("count_keep2", {15'd0, bus.keep}, 16'd1);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("wait_enter", {13'd0, bus.round_state}, 16'd2);
        chk("wait_keep", {15'd0, bus.keep}, 16'd0);

        // Single hit of 25 on player 2
        bus.hit1_req = 1'b1;
        bus.hit1_dmg = 8'd25;
        step();
        chk("h1_state_load", {13'd0, bus.round_state}, 16'd3);
        chk("h1_ack", {14'd0, bus.hit1_ack, bus.hit2_ack}, 16'b10);
        chk("h1_blood_pre", bus.blood_dec, 16'h0019);
        chk("h1_fresh_pre", {15'd0, bus.fresh}, 16'd0);
        bus.hit1_req = 1'b0;
        step();
        chk("h1_fresh", {15'd0, bus.fresh}, 16'd1);
        chk("h1_ack_drop", {15'd0, bus.hit1_ack}, 16'd0);
        chk("h1_blood", bus.blood_dec, 16'h0019);
        chk("h1_p2inv", {14'd0, bus.p1_invuln, bus.p2_invuln}, 16'b01);
        step();
        chk("h1_settle1", {13'd0, bus.round_state}, 16'd5);
        chk("h1_fresh_fall", {15'd0, bus.fresh}, 16'd0);
        chk("h1_blood_hold1", bus.blood_dec, 16'h0019);
        step();
        chk("h1_settle2", {13'd0, bus.round_state}, 16'd5);
        chk("h1_blood_hold2", bus.blood_dec, 16'h0019);
        step();
        chk("h1_back_wait", {13'd0, bus.round_state}, 16'd2);
        chk("h1_blood_clr", bus.blood_dec, 16'd0);

        // Hit on immune player 2: acked, nothing applied
        bus.hit1_req = 1'b1;
        bus.hit1_dmg = 8'd30;
        step();
        chk("imm_ack", {14'd0, bus.hit1_ack, bus.hit2_ack}, 16'b10);
        chk("imm_blood", bus.blood_dec, 16'd0);
        bus.hit1_req = 1'b0;
        step();
        chk("imm_wait", {13'd0, bus.round_state}, 16'd2);
        chk("imm_no_fresh", {15'd0, bus.fresh}, 16'd0);
        chk("imm_still", {15'd0, bus.p2_invuln}, 16'd1);
        do_tick();
        do_tick();
        do_tick();
        chk("imm_3ticks", {15'd0, bus.p2_invuln}, 16'd1);
        do_tick();
        chk("imm_expired", {15'd0, bus.p2_invuln}, 16'd0);

        // Simultaneous hits: 50 clamps to 40, merged with 10
        bus.hit1_req = 1'b1;
        bus.hit1_dmg = 8'd50;
        bus.hit2_req = 1'b1;
        bus.hit2_dmg = 8'd10;
        step();
        chk("sim_acks", {14'd0, bus.hit1_ack, bus.hit2_ack}, 16'b11);
        chk("sim_blood", bus.blood_dec, 16'h0A28);
        chk("sim_fresh_pre", {15'd0, bus.fresh}, 16'd0);
        bus.hit1_req = 1'b0;
        bus.hit2_req = 1'b0;
        step();
        chk("sim_fresh", {15'd0, bus.fresh}, 16'd1);
        chk("sim_blood_p", bus.blood_dec, 16'h0A28);
        chk("sim_inv", {14'd0, bus.p1_invuln, bus.p2_invuln}, 16'b11);
        step();
        chk("sim_fresh_once", {15'd0, bus.fresh}, 16'd0);
        step();
        step();
        chk("sim_wait", {13'd0, bus.round_state}, 16'd2);
        chk("sim_blood_clr", bus.blood_dec, 16'd0);
        do_tick();
        do_tick();
        do_tick();
        do_tick();
        chk("sim_inv_clr", {14'd0, bus.p1_invuln, bus.p2_invuln}, 16'b00);

        // KO: hit on player 1, counter reports over
        bus.hit2_req = 1'b1;
        bus.hit2_dmg = 8'd7;
        step();
        chk("ko_blood", bus.blood_dec, 16'h0700);
        chk("ko_ack2", {14'd0, bus.hit1_ack, bus.hit2_ack}, 16'b01);
        bus.hit2_req = 1'b0;
        step();
        chk("ko_fresh", {15'd0, bus.fresh}, 16'd1);
        step();
        bus.over = 1'b1;
        step();
        chk("ko_settle2", {13'd0, bus.round_state}, 16'd5);
        step();
        chk("ko_state", {13'd0, bus.round_state}, 16'd6);
        chk("ko_keep", {15'd0, bus.keep}, 16'd1);
        chk("ko_blood_clr", bus.blood_dec, 16'd0);
        bus.hit1_req = 1'b1;
        bus.hit1_dmg = 8'd10;
        bus.start    = 1'b1;
        step();
        step();
        chk("ko_no_ack", {14'd0, bus.hit1_ack, bus.hit2_ack}, 16'b00);
        chk("ko_terminal", {13'd0, bus.round_state}, 16'd6);
        chk("ko_no_fresh", {15'd0, bus.fresh}, 16'd0);
        bus.hit1_req = 1'b0;
        bus.start    = 1'b0;

        // New round, request held through COUNT, reset during PULSE
        reset    = 1'b1;
        bus.over = 1'b0;
        step();
        reset = 1'b0;
        chk("r2_idle", {13'd0, bus.round_state}, 16'd0);
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.hit1_req = 1'b1;
        bus.hit1_dmg = 8'd20;
        do_tick();
        do_tick();
        chk("r2_count_noack", {15'd0, bus.hit1_ack}, 16'd0);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("r2_wait", {13'd0, bus.round_state}, 16'd2);
        step();
        chk("r2_ack", {15'd0, bus.hit1_ack}, 16'd1);
        chk("r2_blood", bus.blood_dec, 16'h0014);
        bus.hit1_req = 1'b0;
        step();
        chk("r2_pulse", {13'd0, bus.round_state}, 16'd4);
        chk("r2_fresh", {15'd0, bus.fresh}, 16'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_state", {13'd0, bus.round_state}, 16'd0);
        chk("arst_fresh", {15'd0, bus.fresh}, 16'd0);
        chk("arst_blood", bus.blood_dec, 16'd0);
        chk("arst_invuln", {14'd0, bus.p1_invuln, bus.p2_invuln}, 16'b00);
        chk("arst_keep", {15'd0, bus.keep}, 16'd1);
        step();
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
